// File: rtl/wb_divider_master.sv
// Wishbone classic initiator for the serial divider slave: loads the operands, starts
// the divide, polls STATUS until done, then reads the quotient and remainder back.

module wb_divider_master #(
    parameter int unsigned    WBW         = 32,
    parameter int unsigned    XLEN        = 32,
    parameter logic [WBW-1:0] BASE_ADR    = 32'h3000_0000,
    parameter int unsigned    ACK_TIMEOUT = 64,
    parameter int unsigned    POLL_MAX    = 1024
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [XLEN-1:0]  cmd_dividend_i,
    input  logic [XLEN-1:0]  cmd_divisor_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_quotient_o,
    output logic [XLEN-1:0]  rsp_remainder_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WBW/8-1:0] wbm_sel_o,
    output logic [WBW-1:0]   wbm_adr_o,
    output logic [WBW-1:0]   wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [WBW-1:0]   wbm_dat_i,
    output logic             busy_o
);

    localparam int unsigned    TW        = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned    PW        = $clog2(POLL_MAX + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_MAX - 1);
    localparam logic [WBW-1:0] ADR_CTRL  = BASE_ADR + WBW'(32'h00);
    localparam logic [WBW-1:0] ADR_STAT  = BASE_ADR + WBW'(32'h04);
    localparam logic [WBW-1:0] ADR_DVD   = BASE_ADR + WBW'(32'h08);
    localparam logic [WBW-1:0] ADR_DVS   = BASE_ADR + WBW'(32'h0C);
    localparam logic [WBW-1:0] ADR_QUO   = BASE_ADR + WBW'(32'h10);
    localparam logic [WBW-1:0] ADR_REM   = BASE_ADR + WBW'(32'h14);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DVD  = 3'd1,
        ST_WR_DVS  = 3'd2,
        ST_WR_GO   = 3'd3,
        ST_RD_STAT = 3'd4,
        ST_RD_QUO  = 3'd5,
        ST_RD_REM  = 3'd6,
        ST_RESP    = 3'd7
    } state_t;

    state_t            state_r, next_state_s;
    logic              cyc_r, we_r, cmd_ready_r, rsp_valid_r, busy_r, err_r;
    logic [WBW/8-1:0]  sel_r;
    logic [WBW-1:0]    adr_r, dat_r;
    logic [XLEN-1:0]   dvd_r, dvs_r, quo_r, rem_r;
    logic [TW-1:0]     tmo_cnt_r;
    logic [PW-1:0]     poll_cnt_r;

    logic              accept_s, ack_s, tmo_s, poll_fail_s, is_acc_s, bus_on_s, acc_we_s;
    logic [WBW-1:0]    acc_adr_s, acc_dat_s;

    // Handshake and bus event decode; acks outside an active strobe are ignored
    always_comb begin
        accept_s    = cmd_valid_i && cmd_ready_r;
        ack_s       = cyc_r && wbm_ack_i;
        tmo_s       = cyc_r && !wbm_ack_i && (tmo_cnt_r == TMO_LAST);
        poll_fail_s = (state_r == ST_RD_STAT) && ack_s && !wbm_dat_i[1] && (poll_cnt_r == POLL_LAST);
        is_acc_s    = (state_r != ST_IDLE) && (state_r != ST_RESP);
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:    if (accept_s) next_state_s = ST_WR_DVD; else next_state_s = ST_IDLE;
            ST_WR_DVD:  if (tmo_s) next_state_s = ST_RESP; else if (ack_s) next_state_s = ST_WR_DVS; else next_state_s = state_r;
            ST_WR_DVS:  if (tmo_s) next_state_s = ST_RESP; else if (ack_s) next_state_s = ST_WR_GO;  else next_state_s = state_r;
            ST_WR_GO:   if (tmo_s) next_state_s = ST_RESP; else if (ack_s) next_state_s = ST_RD_STAT; else next_state_s = state_r;
            ST_RD_STAT: begin
                if (tmo_s || poll_fail_s)       next_state_s = ST_RESP;
                else if (ack_s && wbm_dat_i[1]) next_state_s = ST_RD_QUO;
                else                            next_state_s = state_r;
            end
            ST_RD_QUO:  if (tmo_s) next_state_s = ST_RESP; else if (ack_s) next_state_s = ST_RD_REM; else next_state_s = state_r;
            ST_RD_REM:  if (tmo_s || ack_s) next_state_s = ST_RESP; else next_state_s = state_r;
            ST_RESP:    if (rsp_ready_i) next_state_s = ST_IDLE; else next_state_s = ST_RESP;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Bus request for the current access; the IDLE entry pre-loads the dividend write
    // so the strobe rises on the acceptance edge
    always_comb begin
        acc_adr_s = ADR_CTRL;
        acc_we_s  = 1'b0;
        acc_dat_s = {WBW{1'b0}};
        case (state_r)
            ST_IDLE:    begin acc_adr_s = ADR_DVD; acc_we_s = 1'b1; acc_dat_s = WBW'(cmd_dividend_i); end
            ST_WR_DVD:  begin acc_adr_s = ADR_DVD; acc_we_s = 1'b1; acc_dat_s = WBW'(dvd_r); end
            ST_WR_DVS:  begin acc_adr_s = ADR_DVS; acc_we_s = 1'b1; acc_dat_s = WBW'(dvs_r); end
            ST_WR_GO:   begin acc_adr_s = ADR_CTRL; acc_we_s = 1'b1; acc_dat_s = WBW'(32'h1); end
            ST_RD_STAT: acc_adr_s = ADR_STAT;
            ST_RD_QUO:  acc_adr_s = ADR_QUO;
            ST_RD_REM:  acc_adr_s = ADR_REM;
            default:    acc_adr_s = ADR_CTRL;
        endcase
        if (accept_s) begin
            bus_on_s = 1'b1;
        end else if (is_acc_s && !cyc_r) begin
            bus_on_s = 1'b1;
        end else if (is_acc_s && !ack_s && !tmo_s) begin
            bus_on_s = 1'b1;
        end else begin
            bus_on_s = 1'b0;
        end
    end

    // Registered bus, handshake, result and counter state
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= {(WBW/8){1'b0}};
            adr_r       <= {WBW{1'b0}};
            dat_r       <= {WBW{1'b0}};
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            dvd_r       <= {XLEN{1'b0}};
            dvs_r       <= {XLEN{1'b0}};
            quo_r       <= {XLEN{1'b0}};
            rem_r       <= {XLEN{1'b0}};
            tmo_cnt_r   <= {TW{1'b0}};
            poll_cnt_r  <= {PW{1'b0}};
        end else begin
            cyc_r       <= bus_on_s;
            we_r        <= bus_on_s && acc_we_s;
            sel_r       <= bus_on_s ? {(WBW/8){1'b1}} : {(WBW/8){1'b0}};
            adr_r       <= bus_on_s ? acc_adr_s : {WBW{1'b0}};
            dat_r       <= (bus_on_s && acc_we_s) ? acc_dat_s : {WBW{1'b0}};
            cmd_ready_r <= (next_state_s == ST_IDLE);
            rsp_valid_r <= (next_state_s == ST_RESP);
            busy_r      <= (next_state_s != ST_IDLE);
            tmo_cnt_r   <= (cyc_r && !wbm_ack_i) ? tmo_cnt_r + TW'(1) : {TW{1'b0}};
            if (accept_s) begin
                dvd_r      <= cmd_dividend_i;
                dvs_r      <= cmd_divisor_i;
                err_r      <= 1'b0;
                quo_r      <= {XLEN{1'b0}};
                rem_r      <= {XLEN{1'b0}};
                poll_cnt_r <= {PW{1'b0}};
            end else begin
                if (tmo_s || poll_fail_s) err_r <= 1'b1;
                if ((state_r == ST_RD_STAT) && ack_s) poll_cnt_r <= poll_cnt_r + PW'(1);
                if ((state_r == ST_RD_QUO) && ack_s)  quo_r <= wbm_dat_i[XLEN-1:0];
                if ((state_r == ST_RD_REM) && ack_s)  rem_r <= wbm_dat_i[XLEN-1:0];
            end
        end
    end

    assign cmd_ready_o     = cmd_ready_r;
    assign rsp_valid_o     = rsp_valid_r;
    assign rsp_quotient_o  = quo_r;
    assign rsp_remainder_o = rem_r;
    assign rsp_err_o       = err_r;
    assign wbm_cyc_o       = cyc_r;
    assign wbm_stb_o       = cyc_r;
    assign wbm_we_o        = we_r;
    assign wbm_sel_o       = sel_r;
    assign wbm_adr_o       = adr_r;
    assign wbm_dat_o       = dat_r;
    assign busy_o          = busy_r;

endmodule

// File: tb/tb_wb_divider_master.sv
// Self-checking bench: a Wishbone divider slave model with configurable wait states,
// poll depth and a non-acking address, checked against an arithmetic reference model.

module tb_wb_divider_master;

    localparam int          PMAX = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        wb_rst_i, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_dividend, cmd_divisor, rsp_quotient, rsp_remainder;
    logic        wbm_cyc, wbm_stb, wbm_we, busy;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o;
    logic        wbm_ack = 1'b0;
    logic [31:0] wbm_dat_i = 32'h0;

    always #5 clk = ~clk;

    wb_divider_master #(.WBW(32), .XLEN(32), .BASE_ADR(BASE), .ACK_TIMEOUT(64), .POLL_MAX(PMAX)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_dividend_i(cmd_dividend), .cmd_divisor_i(cmd_divisor),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_quotient_o(rsp_quotient), .rsp_remainder_o(rsp_remainder), .rsp_err_o(rsp_err),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack), .wbm_dat_i(wbm_dat_i),
        .busy_o(busy)
    );

    int checks = 0;
    int fails  = 0;

    // slave configuration (written by the stimulus only)
    int          ack_delay  = 0;
    int          done_after = 1;
    logic        no_ack_en  = 1'b0;
    logic [31:0] no_ack_adr = 32'h0;

    // slave state and bus logs (written by the slave/monitor only)
    logic [31:0] s_dvd = 32'h0, s_dvs = 32'h0;
    int          s_polls = 0, s_wait = 0;
    logic        log_we[$];
    logic [31:0] log_adr[$], log_dat[$];
    int          acc_start[$], acc_end[$];
    int          cyc_cnt = 0, sel_bad = 0;
    logic        prev_cyc = 1'b0;

    // reference expectations
    logic        exp_we[$];
    logic [31:0] exp_adr[$], exp_dat[$];

    logic st_done;
    assign st_done = (done_after != 0) && (s_polls + 1 >= done_after);

    // Divider slave: registered ack after ack_delay wait states
    always @(posedge clk) begin
        if (wbm_ack) begin
            wbm_ack <= 1'b0;
        end else if (wbm_cyc && wbm_stb && !(no_ack_en && wbm_adr == no_ack_adr)) begin
            if (s_wait < ack_delay) begin
                s_wait <= s_wait + 1;
            end else begin
                s_wait  <= 0;
                wbm_ack <= 1'b1;
                log_we.push_back(wbm_we);
                log_adr.push_back(wbm_adr);
                log_dat.push_back(wbm_we ? wbm_dat_o : 32'h0);
                if (wbm_we) begin
                    if (wbm_adr == BASE + 32'h08) s_dvd <= wbm_dat_o;
                    else if (wbm_adr == BASE + 32'h0C) s_dvs <= wbm_dat_o;
                    else if (wbm_adr == BASE && wbm_dat_o[0]) s_polls <= 0;
                end else if (wbm_adr == BASE + 32'h04) begin
                    wbm_dat_i <= {30'd0, st_done, !st_done};
                    s_polls   <= s_polls + 1;
                end else if (wbm_adr == BASE + 32'h10) begin
                    wbm_dat_i <= (s_dvs == 32'h0) ? 32'hFFFF_FFFF : s_dvd / s_dvs;
                end else if (wbm_adr == BASE + 32'h14) begin
                    wbm_dat_i <= (s_dvs == 32'h0) ? s_dvd : s_dvd % s_dvs;
                end else begin
                    wbm_dat_i <= 32'h0;
                end
            end
        end else begin
            s_wait <= 0;
        end
    end

    // Bus monitor: access start/end cycles and byte-select sanity
    always @(negedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        prev_cyc <= wbm_cyc;
        if (wbm_cyc && !prev_cyc) acc_start.push_back(cyc_cnt);
        if (!wbm_cyc && prev_cyc) acc_end.push_back(cyc_cnt - 1);
        if (wbm_cyc && wbm_sel != 4'hF) sel_bad <= sel_bad + 1;
    end

    task automatic build_exp(input logic [31:0] a, input logic [31:0] b, input int n_wr, input int n_stat, input bit res);
        exp_we.delete(); exp_adr.delete(); exp_dat.delete();
        if (n_wr >= 1) begin exp_we.push_back(1'b1); exp_adr.push_back(BASE + 32'h08); exp_dat.push_back(a); end
        if (n_wr >= 2) begin exp_we.push_back(1'b1); exp_adr.push_back(BASE + 32'h0C); exp_dat.push_back(b); end
        if (n_wr >= 3) begin exp_we.push_back(1'b1); exp_adr.push_back(BASE); exp_dat.push_back(32'h1); end
        for (int k = 0; k < n_stat; k++) begin
            exp_we.push_back(1'b0); exp_adr.push_back(BASE + 32'h04); exp_dat.push_back(32'h0);
        end
        if (res) begin
            exp_we.push_back(1'b0); exp_adr.push_back(BASE + 32'h10); exp_dat.push_back(32'h0);
            exp_we.push_back(1'b0); exp_adr.push_back(BASE + 32'h14); exp_dat.push_back(32'h0);
        end
    endtask

    function automatic int log_diffs();
        int d = 0;
        if (log_adr.size() != exp_adr.size()) d++;
        for (int k = 0; k < log_adr.size() && k < exp_adr.size(); k++)
            if (log_we[k] !== exp_we[k] || log_adr[k] !== exp_adr[k] || log_dat[k] !== exp_dat[k]) d++;
        return d;
    endfunction

    function automatic int bad_gaps();
        int n = 0;
        for (int k = 1; k < acc_start.size() && k <= acc_end.size(); k++)
            if (acc_start[k] - acc_end[k-1] - 1 != 1) n++;
        return n;
    endfunction

    task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, output logic [31:0] q,
                          output logic [31:0] r, output logic e, output int lat, output logic cyc_at);
        int n;
        @(posedge clk);
        log_we.delete(); log_adr.delete(); log_dat.delete(); acc_start.delete(); acc_end.delete();
        @(negedge clk);
        cmd_dividend = a; cmd_divisor = b; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!cmd_ready) begin
            fails++; $display("FAIL accept_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 1'b0; q = 32'h0; r = 32'h0; e = 1'b0; lat = -1; cyc_at = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
        checks++;
        if (!rsp_valid) begin fails++; $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat); end
        q = rsp_quotient; r = rsp_remainder; e = rsp_err; cyc_at = wbm_cyc;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        checks++; if ({rsp_valid, rsp_err, busy} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b required 000", {rsp_valid, rsp_err, busy}); end
        checks++; if ({wbm_cyc, wbm_stb, wbm_we, wbm_sel} !== 7'h0) begin fails++; $display("FAIL reset_bus_ctl: got %h required 0", {wbm_cyc, wbm_stb, wbm_we, wbm_sel}); end
        checks++; if ({wbm_adr, wbm_dat_o} !== 64'h0) begin fails++; $display("FAIL reset_bus_data: got %h required 0", {wbm_adr, wbm_dat_o}); end
        checks++; if ({rsp_quotient, rsp_remainder} !== 64'h0) begin fails++; $display("FAIL reset_results: got %h required 0", {rsp_quotient, rsp_remainder}); end
        wb_rst_i = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] q, r; logic e, ca; int lat;
        ack_delay = 0; done_after = 1;
        do_cmd(32'd100, 32'd7, q, r, e, lat, ca);
        build_exp(32'd100, 32'd7, 3, 1, 1'b1);
        checks++; if (lat !== 18) begin fails++; $display("FAIL basic_latency: got %0d required 18", lat); end
        checks++; if (q !== 32'd14) begin fails++; $display("FAIL basic_quotient: got %0d required 14", q); end
        checks++; if (r !== 32'd2) begin fails++; $display("FAIL basic_remainder: got %0d required 2", r); end
        checks++; if (e !== 1'b0) begin fails++; $display("FAIL basic_err: got %b required 0", e); end
        checks++; if (log_diffs() !== 0) begin fails++; $display("FAIL basic_bus_seq: got %0d differing accesses required 0", log_diffs()); end
        checks++; if (bad_gaps() !== 0) begin fails++; $display("FAIL basic_gaps: got %0d bad idle gaps required 0", bad_gaps()); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r; logic e, ca; int lat, nacc;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (b == 32'h0) b = 32'h1;
            ack_delay  = $urandom_range(0, 3);
            done_after = $urandom_range(1, 5);
            do_cmd(a, b, q, r, e, lat, ca);
            build_exp(a, b, 3, done_after, 1'b1);
            nacc = 5 + done_after;
            checks++; if (q !== a / b || r !== a % b || e !== 1'b0) begin
                fails++; $display("FAIL random_result[%0d]: got q=%h r=%h e=%b required q=%h r=%h e=0", i, q, r, e, a / b, a % b);
            end
            checks++; if (lat !== nacc * (3 + ack_delay)) begin fails++; $display("FAIL random_latency[%0d]: got %0d required %0d", i, lat, nacc * (3 + ack_delay)); end
            checks++; if (log_diffs() !== 0 || bad_gaps() !== 0) begin fails++; $display("FAIL random_bus[%0d]: got %0d seq diffs %0d bad gaps required 0", i, log_diffs(), bad_gaps()); end
        end
        ack_delay = 0;
    endtask

    task automatic test_poll();
        logic [31:0] q, r; logic e, ca; int lat;
        done_after = 4;
        do_cmd(32'hFFFF_FFFF, 32'h10, q, r, e, lat, ca);
        build_exp(32'hFFFF_FFFF, 32'h10, 3, 4, 1'b1);
        checks++; if (log_diffs() !== 0) begin fails++; $display("FAIL poll_bus_seq: got %0d differing accesses required 0", log_diffs()); end
        checks++; if (bad_gaps() !== 0) begin fails++; $display("FAIL poll_gaps: got %0d bad idle gaps required 0", bad_gaps()); end
        checks++; if (q !== 32'h0FFF_FFFF || r !== 32'hF || e !== 1'b0) begin fails++; $display("FAIL poll_result: got q=%h r=%h e=%b required q=0fffffff r=f e=0", q, r, e); end
        checks++; if (lat !== 27) begin fails++; $display("FAIL poll_latency: got %0d required 27", lat); end
        done_after = 1;
    endtask

    task automatic test_timeout();
        logic [31:0] q, r; logic e, ca; int lat, dur;
        no_ack_en = 1'b1; no_ack_adr = BASE + 32'h0C;
        do_cmd(32'd500, 32'd9, q, r, e, lat, ca);
        no_ack_en = 1'b0;
        build_exp(32'd500, 32'd9, 1, 0, 1'b0);
        dur = (acc_start.size() >= 2 && acc_end.size() >= 2) ? acc_end[1] - acc_start[1] + 1 : -1;
        checks++; if (dur !== 64) begin fails++; $display("FAIL timeout_stb_len: got %0d required 64", dur); end
        checks++; if (e !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b required 1", e); end
        checks++; if (q !== 32'h0 || r !== 32'h0) begin fails++; $display("FAIL timeout_results: got q=%h r=%h required 0 0", q, r); end
        checks++; if (ca !== 1'b0) begin fails++; $display("FAIL timeout_cyc: got %b required 0", ca); end
        checks++; if (lat !== 68) begin fails++; $display("FAIL timeout_latency: got %0d required 68", lat); end
        checks++; if (log_diffs() !== 0) begin fails++; $display("FAIL timeout_bus_seq: got %0d differing accesses required 0", log_diffs()); end
    endtask

    task automatic test_poll_limit();
        logic [31:0] q, r; logic e, ca; int lat, nstat;
        done_after = 0;
        do_cmd(32'd77, 32'd5, q, r, e, lat, ca);
        build_exp(32'd77, 32'd5, 3, PMAX, 1'b0);
        nstat = 0;
        foreach (log_adr[k]) if (log_adr[k] == BASE + 32'h04) nstat++;
        checks++; if (nstat !== PMAX) begin fails++; $display("FAIL polllim_reads: got %0d required %0d", nstat, PMAX); end
        checks++; if (e !== 1'b1 || q !== 32'h0 || r !== 32'h0) begin fails++; $display("FAIL polllim_result: got e=%b q=%h r=%h required 1 0 0", e, q, r); end
        checks++; if (log_diffs() !== 0) begin fails++; $display("FAIL polllim_bus_seq: got %0d differing accesses required 0", log_diffs()); end
        checks++; if (lat !== (3 + PMAX) * 3) begin fails++; $display("FAIL polllim_latency: got %0d required %0d", lat, (3 + PMAX) * 3); end
        done_after = 1;
    endtask

    task automatic test_backpressure();
        logic [31:0] q0, r0; logic e0; int n, unstable;
        @(negedge clk);
        cmd_dividend = 32'd1000; cmd_divisor = 32'd33; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_dividend = 32'd77; cmd_divisor = 32'd5;
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        q0 = rsp_quotient; r0 = rsp_remainder; e0 = rsp_err;
        checks++; if (q0 !== 32'd30 || r0 !== 32'd10 || e0 !== 1'b0) begin fails++; $display("FAIL bp_result: got q=%0d r=%0d e=%b required 30 10 0", q0, r0, e0); end
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_quotient !== q0 || rsp_remainder !== r0 || rsp_err !== e0 || cmd_ready !== 1'b0) unstable++;
            @(negedge clk);
        end
        checks++; if (unstable !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles required 0", unstable); end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_idle: got ready=%b valid=%b required 1 0", cmd_ready, rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || wbm_cyc !== 1'b1 || wbm_adr !== BASE + 32'h08 || wbm_dat_o !== 32'd77) begin
            fails++; $display("FAIL bp_next_accept: got busy=%b ready=%b cyc=%b adr=%h dat=%h required 1 0 1 %h 4d", busy, cmd_ready, wbm_cyc, wbm_adr, wbm_dat_o, BASE + 32'h08);
        end
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        checks++; if (rsp_quotient !== 32'd15 || rsp_remainder !== 32'd2) begin fails++; $display("FAIL bp_second: got q=%0d r=%0d required 15 2", rsp_quotient, rsp_remainder); end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r; logic e, ca; int lat, n;
        done_after = 0;
        @(negedge clk);
        cmd_dividend = 32'd500; cmd_divisor = 32'd6; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(wbm_cyc && wbm_adr == BASE + 32'h04) && n < 500) begin @(negedge clk); n++; end
        checks++; if (!(wbm_cyc && wbm_adr == BASE + 32'h04)) begin fails++; $display("FAIL rstmid_reach_stat: got cyc=%b adr=%h required 1 %h", wbm_cyc, wbm_adr, BASE + 32'h04); end
        wb_rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb_rst_i = 1'b0;
        checks++; if ({wbm_cyc, wbm_stb, rsp_valid, cmd_ready, busy} !== 5'b00010) begin
            fails++; $display("FAIL rstmid_state: got cyc,stb,valid,ready,busy=%b required 00010", {wbm_cyc, wbm_stb, rsp_valid, cmd_ready, busy});
        end
        repeat (3) @(negedge clk);
        done_after = 1;
        do_cmd(32'd9, 32'd3, q, r, e, lat, ca);
        build_exp(32'd9, 32'd3, 3, 1, 1'b1);
        checks++; if (q !== 32'd3 || r !== 32'd0 || e !== 1'b0) begin fails++; $display("FAIL rstmid_result: got q=%0d r=%0d e=%b required 3 0 0", q, r, e); end
        checks++; if (log_diffs() !== 0 || lat !== 18) begin fails++; $display("FAIL rstmid_bus: got %0d seq diffs latency %0d required 0 18", log_diffs(), lat); end
    endtask

    initial begin
        wb_rst_i = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_dividend = 32'h0; cmd_divisor = 32'h0;
        test_reset();
        test_basic();
        test_random();
        test_poll();
        test_timeout();
        test_poll_limit();
        test_backpressure();
        test_reset_mid();
        checks++; if (sel_bad !== 0) begin fails++; $display("FAIL sel_all_ones: got %0d bad cycles required 0", sel_bad); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
